// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: central stall/flush sequencer for the 5-stage core.
// Merges the load-use hazard flag, EX-stage branch-taken and a multi-cycle
// SRAM handshake into per-stage register enable/flush controls. It also
// strobes SRAM starts and keeps a saturating count of cycles the PC is held.
//
// Build option: define PIPE_CTRL_TIMEOUT_EN to add a MEM_WAIT watchdog.
// After MEM_TIMEOUT wait cycles without mem_ready, the watchdog forces a
// release and sets the sticky mem_error flag. Without the macro, MEM_WAIT
// lasts until mem_ready and mem_error is tied low.

module pipeline_stall_ctrl #(
    parameter int MEM_TIMEOUT = 64,  // watchdog depth in MEM_WAIT cycles, >= 2
    parameter int CNT_W       = 16   // stall counter width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             mem_start,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mem_error
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic in_run, in_wait;
    logic timeout;      // watchdog forces the end of the access this cycle
    logic release_c;    // last MEM_WAIT cycle: pipeline advances
    logic freeze;       // whole pipeline held for the SRAM

    logic pc_en_c, if_id_en_c, if_id_flush_c, id_ex_bubble_c;
    logic ex_mem_en_c, mem_wb_en_c;

    assign in_run  = (state_q == RUN);
    assign in_wait = (state_q == MEM_WAIT);

`ifdef PIPE_CTRL_TIMEOUT_EN
    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_error_q, mem_error_d;

    assign timeout = in_wait & ~mem_ready
                   & (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));

    // Wait counter sits at zero in RUN so it reads zero on MEM_WAIT entry;
    // the error flag is sticky until reset.
    always_comb begin
        wait_cnt_d  = '0;
        mem_error_d = mem_error_q | timeout;
        if (in_wait) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign mem_error = mem_error_q;
`else
    // The timeout depth has no effect without the watchdog.
    localparam int unused_mem_timeout = MEM_TIMEOUT;

    assign timeout   = 1'b0;
    assign mem_error = 1'b0;
`endif

    assign release_c = in_wait & (mem_ready | timeout);
    assign freeze    = (in_run & mem_req) | (in_wait & ~release_c);

    // Next state: a RUN cycle with mem_req starts an access; release ends it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_d = state_q;
        unique case (state_q)
            RUN:      if (mem_req)   state_d = MEM_WAIT;
            MEM_WAIT: if (release_c) state_d = RUN;
            default:                 state_d = RUN;
        endcase
    end

    // Stage controls. Freeze wins and hides hazard/branch, which stay held
    // in the frozen registers. Otherwise branch flush beats the load-use stall.
    always_comb begin
        pc_en_c        = 1'b1;
        if_id_en_c     = 1'b1;
        if_id_flush_c  = 1'b0;
        id_ex_bubble_c = 1'b0;
        ex_mem_en_c    = 1'b1;
        mem_wb_en_c    = 1'b1;
        if (freeze) begin
            pc_en_c     = 1'b0;
            if_id_en_c  = 1'b0;
            ex_mem_en_c = 1'b0;
            mem_wb_en_c = 1'b0;
        end else if (branch_taken) begin
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
        end else if (hazard) begin
            pc_en_c        = 1'b0;
            if_id_en_c     = 1'b0;
            id_ex_bubble_c = 1'b1;
        end
    end

    // Stall counter: clear beats increment, saturates at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
        end else if (!pc_en_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Outputs are forced low while reset is asserted. An abort in MEM_WAIT
    // lands in RUN, so the next strobe needs a fresh mem_req.
    assign pc_en        = rst_n & pc_en_c;
    assign if_id_en     = rst_n & if_id_en_c;
    assign if_id_flush  = rst_n & if_id_flush_c;
    assign id_ex_bubble = rst_n & id_ex_bubble_c;
    assign ex_mem_en    = rst_n & ex_mem_en_c;
    assign mem_wb_en    = rst_n & mem_wb_en_c;
    assign mem_start    = rst_n & in_run & mem_req;
    assign busy         = rst_n & in_wait;
    assign stall_cnt    = stall_cnt_q;

endmodule
